// File: rtl/rsqrt_seed_iterator.sv
// rsqrt_seed_iterator: seeds and drives newtons_method_rsqrt to produce 1/sqrt(x)
// for one fixed-point operand at a time.
// Optional feature macro: RSQRT_SEED_EARLY_EXIT_EN (stop iterating once the
// guess moves by at most one LSB between passes).
// Also contains the ransac_fixed package and the newtons_method_rsqrt child,
// so that this file stands on its own.

package ransac_fixed;
  localparam int VALUE_BITS    = 32;
  localparam int FRACTION_BITS = 16;

  typedef logic signed [VALUE_BITS-1:0] fixed_t;

  function automatic int value_bits();
    return VALUE_BITS;
  endfunction

  function automatic int fraction_bits();
    return FRACTION_BITS;
  endfunction
endpackage

// newtons_method_rsqrt: one Newton step g' = g * (3 - x*g^2) / 2.
// Takes one operand pair at a time; output_valid pulses for one cycle,
// 3*multiply_latency+1 cycles after the accepting cycle. input_ready is low
// while a step is in flight. The step result saturates to the signed range.
module newtons_method_rsqrt #(
  parameter int value_bits       = ransac_fixed::value_bits(),
  parameter int fraction_bits    = ransac_fixed::fraction_bits(),
  parameter int multiply_latency = ransac_fixed::value_bits() / 16,
  parameter bit reset_polarity   = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  input_valid,
  output logic                  input_ready,
  input  logic [value_bits-1:0] number,
  input  logic [value_bits-1:0] old_guess,
  output logic                  output_valid,
  output logic [value_bits-1:0] new_guess
);
  localparam int LATENCY = 3 * multiply_latency + 1;
  localparam int CW      = $clog2(LATENCY + 1);
  localparam int PW      = 3 * value_bits;

  localparam logic signed [PW-1:0] MAX_VALUE = PW'((64'(1) << (value_bits - 1)) - 64'(1));
  localparam logic signed [PW-1:0] MIN_VALUE = -MAX_VALUE - PW'(1);

  logic                 reset_n;
  logic                 busy;
  logic [CW-1:0]        countdown;
  logic signed [PW-1:0] x_wide;
  logic signed [PW-1:0] g_wide;
  logic signed [PW-1:0] g_squared;
  logic signed [PW-1:0] x_g_squared;
  logic signed [PW-1:0] three;
  logic signed [PW-1:0] correction;
  logic signed [PW-1:0] step_wide;
  logic [value_bits-1:0] step_result;

  assign reset_n = reset_polarity ? ~reset : reset;

  // Wide combinational Newton step, saturated back to the operand width
  always_comb begin
    x_wide      = {{(PW - value_bits){number[value_bits-1]}}, number};
    g_wide      = {{(PW - value_bits){old_guess[value_bits-1]}}, old_guess};
    g_squared   = (g_wide * g_wide) >>> fraction_bits;
    x_g_squared = (x_wide * g_squared) >>> fraction_bits;
    three       = PW'(3) <<< fraction_bits;
    correction  = three - x_g_squared;
    step_wide   = (g_wide * correction) >>> (fraction_bits + 1);
    step_result = step_wide[value_bits-1:0];
    if (step_wide > MAX_VALUE) begin
      step_result = MAX_VALUE[value_bits-1:0];
    end else if (step_wide < MIN_VALUE) begin
      step_result = MIN_VALUE[value_bits-1:0];
    end
  end

  // Capture the step on accept and count down the modelled multiplier latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy      <= 1'b0;
      countdown <= '0;
      new_guess <= '0;
    end else if (input_valid && input_ready) begin
      busy      <= 1'b1;
      countdown <= CW'(LATENCY - 1);
      new_guess <= step_result;
    end else if (busy) begin
      if (countdown == '0) begin
        busy <= 1'b0;
      end else begin
        countdown <= countdown - 1'b1;
      end
    end
  end

  assign input_ready  = !busy;
  assign output_valid = busy && (countdown == '0);
endmodule

module rsqrt_seed_iterator #(
  parameter int iterations       = 3,
  parameter int fraction_bits    = ransac_fixed::fraction_bits(),
  parameter int multiply_latency = ransac_fixed::value_bits() / 16
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                input_valid,
  output logic                                input_ready,
  input  logic [ransac_fixed::VALUE_BITS-1:0] number,
  output logic                                output_valid,
  input  logic                                output_ready,
  output logic [ransac_fixed::VALUE_BITS-1:0] result,
  output logic                                domain_error,
  output logic [3:0]                          iterations_used
);
  localparam int W = ransac_fixed::VALUE_BITS;
  localparam logic [W-1:0] ONE = W'(1) << fraction_bits;

  typedef enum logic [2:0] {
    IDLE,
    SEED,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t       state;
  state_t       state_next;

  logic [W-1:0] x_reg;
  logic [W-1:0] guess;
  logic [3:0]   pass_count;
  logic [3:0]   pass_next;
  logic         error_flag;

  int           msb_index;
  int           seed_exponent;
  int           seed_shift;
  logic         seed_error;
  logic [W-1:0] seed_guess;

  logic         child_valid;
  logic         child_ready;
  logic         child_output_valid;
  logic [W-1:0] child_new_guess;
  logic         converged;
  logic         finish_pass;

  newtons_method_rsqrt #(
    .value_bits       (W),
    .fraction_bits    (fraction_bits),
    .multiply_latency (multiply_latency),
    .reset_polarity   (1'b0)
  ) newton_step (
    .clock        (clock),
    .reset        (reset),
    .input_valid  (child_valid),
    .input_ready  (child_ready),
    .number       (x_reg),
    .old_guess    (guess),
    .output_valid (child_output_valid),
    .new_guess    (child_new_guess)
  );

  // Power-of-two seed from the leading one: g0 = 2^-ceil(e/2), e = msb - F
  always_comb begin
    msb_index = 0;
    for (int i = 0; i < W; i++) begin
      if (x_reg[i]) begin
        msb_index = i;
      end
    end
    seed_exponent = msb_index - fraction_bits;
    seed_shift    = (seed_exponent + 1) >>> 1;
    seed_error    = 1'b0;
    seed_guess    = '0;
    if (x_reg[W-1] || (x_reg == '0)) begin
      seed_error = 1'b1;
    end else if (seed_shift >= 0) begin
      if (seed_shift > fraction_bits) begin
        seed_error = 1'b1;
      end else begin
        seed_guess = ONE >> seed_shift;
      end
    end else begin
      if ((fraction_bits - seed_shift) >= (W - 1)) begin
        seed_error = 1'b1;
      end else begin
        seed_guess = ONE << (-seed_shift);
      end
    end
  end

`ifdef RSQRT_SEED_EARLY_EXIT_EN
  logic signed [W:0] guess_step;

  // Stop early once a pass moves the guess by at most one LSB
  always_comb begin
    guess_step = $signed({child_new_guess[W-1], child_new_guess}) - $signed({guess[W-1], guess});
    converged  = (guess_step == '0) || (guess_step == '1) || (guess_step == (W + 1)'(1));
  end
`else
  assign converged = 1'b0;
`endif

  assign pass_next   = pass_count + 4'd1;
  assign finish_pass = (pass_next == 4'(iterations)) || converged;

  // Control state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic and the one-cycle child request
  always_comb begin
    state_next  = state;
    child_valid = 1'b0;
    case (state)
      IDLE: begin
        if (input_valid) begin
          state_next = SEED;
        end
      end
      SEED: begin
        state_next = seed_error ? DONE : ISSUE;
      end
      ISSUE: begin
        if (child_ready) begin
          child_valid = 1'b1;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (child_output_valid) begin
          state_next = finish_pass ? DONE : ISSUE;
        end
      end
      DONE: begin
        if (output_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand, running guess, pass counter and error flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_reg      <= '0;
      guess      <= '0;
      pass_count <= '0;
      error_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (input_valid) begin
            x_reg      <= number;
            guess      <= '0;
            pass_count <= '0;
            error_flag <= 1'b0;
          end
        end
        SEED: begin
          guess      <= seed_guess;
          error_flag <= seed_error;
        end
        WAIT: begin
          if (child_output_valid) begin
            guess      <= child_new_guess;
            pass_count <= pass_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign input_ready     = (state == IDLE);
  assign output_valid    = (state == DONE);
  assign result          = output_valid ? guess : '0;
  assign domain_error    = output_valid && error_flag;
  assign iterations_used = output_valid ? pass_count : 4'd0;
endmodule
